// File: rtl/slc3_datapath_gen_if.sv
// Memory handshake between the SLC-3 datapath (master) and the SRAM controller (slave).
// The master holds request, qualifier, address and write data stable until mem_ready.
interface slc3_datapath_gen_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/slc3_datapath_gen.sv
// SLC-3 datapath: PC/MAR/MDR/IR, 8-entry register file, ALU, address adder, gated bus,
// NZP/BEN logic and a ready-based memory FSM with timeout.
//   state | meaning
//   IDLE  | no memory transaction; MDR may load from the bus
//   RD    | read in flight; MDR takes mem_rdata on mem_ready
//   WR    | write of latched MDR to latched MAR in flight
module slc3_datapath_gen #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               LD_MAR,
    input  logic               LD_MDR,
    input  logic               LD_IR,
    input  logic               LD_REG,
    input  logic               LD_PC,
    input  logic               LD_CC,
    input  logic               LD_BEN,
    input  logic               GatePC,
    input  logic               GateMDR,
    input  logic               GateALU,
    input  logic               GateMARMUX,
    input  logic               SR2MUX,
    input  logic               ADDR1MUX,
    input  logic               DRMUX,
    input  logic               SR1MUX,
    input  logic               MIO_EN,
    input  logic [1:0]         PCMUX,
    input  logic [1:0]         ADDR2MUX,
    input  logic [1:0]         ALUK,
    input  logic               MEM_WR,
    slc3_datapath_gen_if.master mem,
    output logic               mem_busy,
    output logic               mem_err,
    output logic               bus_err,
    output logic [DATA_W-1:0]  IR,
    output logic [DATA_W-1:0]  PC,
    output logic [DATA_W-1:0]  MAR,
    output logic [DATA_W-1:0]  MDR,
    output logic [DATA_W-1:0]  bus,
    output logic [2:0]         CC,
    output logic               BEN
);
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} mem_state_t;

    mem_state_t        state;
    logic [TW-1:0]     tmo_cnt;
    logic              req_q, we_q;
    logic [DATA_W-1:0] addr_q, wdata_q;

    logic [DATA_W-1:0] reg_file [8];
    logic [2:0]        dr, sr1;
    logic [DATA_W-1:0] sr1_val, sr2_val, alu_b, alu_out;
    logic [DATA_W-1:0] addr1, addr2, adder_out, pc_next;
    logic [3:0]        gates;
    logic              gate_conflict;
    logic              bus_neg, bus_zero;

    assign dr      = DRMUX ? 3'd7 : IR[11:9];
    assign sr1     = SR1MUX ? IR[8:6] : IR[11:9];
    assign sr1_val = reg_file[sr1];
    assign sr2_val = reg_file[IR[2:0]];
    assign alu_b   = SR2MUX ? {{(DATA_W-5){IR[4]}}, IR[4:0]} : sr2_val;

    always_comb begin
        alu_out = sr1_val;
        unique case (ALUK)
            2'b00: alu_out = sr1_val + alu_b;
            2'b01: alu_out = sr1_val & alu_b;
            2'b10: alu_out = ~sr1_val;
            2'b11: alu_out = sr1_val;
        endcase
    end

    assign addr1 = ADDR1MUX ? sr1_val : PC;

    always_comb begin
        addr2 = '0;
        unique case (ADDR2MUX)
            2'b00: addr2 = '0;
            2'b01: addr2 = {{(DATA_W-6){IR[5]}},  IR[5:0]};
            2'b10: addr2 = {{(DATA_W-9){IR[8]}},  IR[8:0]};
            2'b11: addr2 = {{(DATA_W-11){IR[10]}}, IR[10:0]};
        endcase
    end

    assign adder_out = addr1 + addr2;

    always_comb begin
        pc_next = PC;
        unique case (PCMUX)
            2'b00: pc_next = PC + DATA_W'(1);
            2'b01: pc_next = bus;
            2'b10: pc_next = adder_out;
            2'b11: pc_next = PC;
        endcase
    end

    // More than one driver is treated as contention: the bus reads as zero.
    assign gates         = {GatePC, GateMDR, GateALU, GateMARMUX};
    assign gate_conflict = (gates & (gates - 4'd1)) != 4'd0;

    always_comb begin
        bus = '0;
        unique case (gates)
            4'b1000: bus = PC;
            4'b0100: bus = MDR;
            4'b0010: bus = alu_out;
            4'b0001: bus = adder_out;
            default: bus = '0;
        endcase
    end

    assign bus_neg  = bus[DATA_W-1];
    assign bus_zero = (bus == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            PC      <= RESET_PC;
            IR      <= '0;
            MAR     <= '0;
            CC      <= 3'b010;
            BEN     <= 1'b0;
            bus_err <= 1'b0;
            for (int i = 0; i < 8; i++) reg_file[i] <= '0;
        end else begin
            if (LD_PC)  PC  <= pc_next;
            if (LD_IR)  IR  <= bus;
            if (LD_MAR) MAR <= bus;
            if (LD_REG) reg_file[dr] <= bus;
            if (LD_CC)  CC  <= {bus_neg, bus_zero, ~bus_neg & ~bus_zero};
            if (LD_BEN) BEN <= |(IR[11:9] & CC);
            if (gate_conflict) bus_err <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_cnt <= '0;
            mem_err <= 1'b0;
            MDR     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    addr_q  <= MAR;
                    wdata_q <= MDR;
                    tmo_cnt <= TW'(MEM_TIMEOUT);
                    if (LD_MDR && MIO_EN) begin
                        state <= RD;
                        req_q <= 1'b1;
                        we_q  <= 1'b0;
                    end else begin
                        if (LD_MDR) MDR <= bus;
                        if (MEM_WR) begin
                            state <= WR;
                            req_q <= 1'b1;
                            we_q  <= 1'b1;
                        end
                    end
                end
                RD, WR: begin
                    if (mem.mem_ready) begin
                        if (state == RD) MDR <= mem.mem_rdata;
                        state <= IDLE;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                    end else if (MEM_TIMEOUT != 0 && tmo_cnt == TW'(1)) begin
                        state   <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        mem_err <= 1'b1;
                    end else if (MEM_TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_busy      = (state != IDLE);
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_slc3_datapath_gen.sv
// Bench for slc3_datapath_gen: directed corner sequences, an ALU/adder vector table,
// and random control traffic checked against a behavioural model.
module tb_slc3_datapath_gen;
    logic        Clk, Reset;
    logic        LD_MAR, LD_MDR, LD_IR, LD_REG, LD_PC, LD_CC, LD_BEN;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic        SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        MEM_WR;
    logic        mem_busy, mem_err, bus_err, BEN;
    logic [15:0] IR, PC, MAR, MDR, bus;
    logic [2:0]  CC;

    int n_chk  = 0;
    int n_fail = 0;

    slc3_datapath_gen_if #(.DATA_W(16)) mem_if ();

    slc3_datapath_gen #(.DATA_W(16), .RESET_PC(16'h3000), .MEM_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_REG(LD_REG),
        .LD_PC(LD_PC), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
        .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .MEM_WR(MEM_WR), .mem(mem_if),
        .mem_busy(mem_busy), .mem_err(mem_err), .bus_err(bus_err),
        .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR), .bus(bus), .CC(CC), .BEN(BEN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_ctl();
        {LD_MAR, LD_MDR, LD_IR, LD_REG, LD_PC, LD_CC, LD_BEN} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
        {SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN} = '0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00; MEM_WR = 1'b0;
    endtask

    // Read completes on the lat-th edge after the start edge.
    task automatic mem_read(input logic [15:0] d, input int lat,
                            output int req_cycles, output logic [15:0] addr_seen);
        clr_ctl();
        LD_MDR = 1'b1; MIO_EN = 1'b1;
        tick();
        clr_ctl();
        req_cycles = 0;
        addr_seen  = mem_if.mem_addr;
        for (int i = 1; i <= lat; i++) begin
            if (mem_if.mem_req) req_cycles++;
            if (i == lat) begin
                mem_if.mem_ready = 1'b1;
                mem_if.mem_rdata = d;
            end
            tick();
        end
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 16'($urandom);
    endtask

    task automatic load_ir(input logic [15:0] v);
        int rc; logic [15:0] a;
        mem_read(v, 1, rc, a);
        GateMDR = 1'b1; LD_IR = 1'b1;
        tick();
        clr_ctl();
    endtask

    task automatic write_reg(input logic [2:0] n, input logic [15:0] v);
        int rc; logic [15:0] a;
        load_ir({4'h0, n, 9'h000});
        mem_read(v, 1, rc, a);
        GateMDR = 1'b1; LD_REG = 1'b1;
        tick();
        clr_ctl();
    endtask

    // Behavioural reference model
    logic [15:0] m_pc, m_ir, m_mar, m_mdr;
    logic [15:0] m_r [8];
    logic [2:0]  m_cc;
    logic        m_ben, m_berr;

    function automatic logic [15:0] sext(input logic [15:0] v, input int k);
        logic [15:0] m;
        m = 16'hFFFF << k;
        return v[k-1] ? (v | m) : (v & ~m);
    endfunction

    task automatic model_reset();
        m_pc = 16'h3000; m_ir = '0; m_mar = '0; m_mdr = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_cc = 3'b010; m_ben = 1'b0; m_berr = 1'b0;
    endtask

    task automatic rand_step();
        int n_g, g;
        logic [3:0]  gv;
        logic [15:0] a, b, alu, add, nb;
        logic [2:0]  dr;
        logic        n_new_ben;
        clr_ctl();
        g = $urandom_range(0, 9);
        if (g == 9) begin
            do gv = 4'($urandom); while ($countones(gv) < 2);
        end else if (g == 0) gv = 4'b0000;
        else gv = 4'b0001 << ((g - 1) / 2);
        {GatePC, GateMDR, GateALU, GateMARMUX} = gv;
        {LD_MAR, LD_MDR, LD_IR, LD_REG, LD_PC, LD_CC, LD_BEN} = 7'($urandom);
        {SR2MUX, ADDR1MUX, DRMUX, SR1MUX} = 4'($urandom);
        PCMUX = 2'($urandom); ADDR2MUX = 2'($urandom); ALUK = 2'($urandom);
        #1;
        a = m_r[SR1MUX ? m_ir[8:6] : m_ir[11:9]];
        b = SR2MUX ? sext(m_ir, 5) : m_r[m_ir[2:0]];
        case (ALUK)
            2'b00: alu = a + b;
            2'b01: alu = a & b;
            2'b10: alu = ~a;
            default: alu = a;
        endcase
        case (ADDR2MUX)
            2'b00: add = 16'h0;
            2'b01: add = sext(m_ir, 6);
            2'b10: add = sext(m_ir, 9);
            default: add = sext(m_ir, 11);
        endcase
        add = (ADDR1MUX ? a : m_pc) + add;
        n_g = $countones(gv);
        if (n_g != 1) nb = 16'h0;
        else if (GatePC) nb = m_pc;
        else if (GateMDR) nb = m_mdr;
        else if (GateALU) nb = alu;
        else nb = add;
        check("rnd_bus", bus, nb);
        dr = DRMUX ? 3'd7 : m_ir[11:9];
        n_new_ben = |(m_ir[11:9] & m_cc);
        if (n_g > 1) m_berr = 1'b1;
        if (LD_BEN) m_ben = n_new_ben;
        if (LD_CC) m_cc = nb[15] ? 3'b100 : (nb == 0) ? 3'b010 : 3'b001;
        if (LD_PC) begin
            case (PCMUX)
                2'b00: m_pc = m_pc + 16'd1;
                2'b01: m_pc = nb;
                2'b10: m_pc = add;
                default: m_pc = m_pc;
            endcase
        end
        if (LD_REG) m_r[dr] = nb;
        if (LD_IR)  m_ir = nb;
        if (LD_MAR) m_mar = nb;
        if (LD_MDR) m_mdr = nb;
        tick();
        clr_ctl();
        check("rnd_pc", PC, m_pc);
        check("rnd_ir", IR, m_ir);
        check("rnd_mar", MAR, m_mar);
        check("rnd_mdr", MDR, m_mdr);
        check("rnd_cc", CC, m_cc);
        check("rnd_ben", BEN, m_ben);
        check("rnd_bus_err", bus_err, m_berr);
        check("rnd_busy", mem_busy, 1'b0);
    endtask

    typedef struct {
        logic [15:0] ir;
        logic        sr1mux;
        logic        sr2mux;
        logic [1:0]  aluk;
        logic        addr1mux;
        logic [1:0]  addr2mux;
        logic        use_adder;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int rc, cnt;
        logic [15:0] aseen;

        // ir, sr1mux, sr2mux, aluk, addr1mux, addr2mux, use_adder, expected bus
        // Context: PC=3000, R1=7FFF, R2=8000, R3=0F0F
        vecs[0]  = '{16'h0042, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'hFFFF};
        vecs[1]  = '{16'h0043, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 16'h0F0F};
        vecs[2]  = '{16'h0080, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 16'h7FFF};
        vecs[3]  = '{16'h005F, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'h7FFE};
        vecs[4]  = '{16'h0600, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 16'h0F0F};
        vecs[5]  = '{16'h0020, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 16'h2FE0};
        vecs[6]  = '{16'h00FF, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 16'h30FF};
        vecs[7]  = '{16'h0400, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b1, 16'h2C00};
        vecs[8]  = '{16'h0080, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 16'h8000};
        vecs[9]  = '{16'h0041, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 16'h8000};
        vecs[10] = '{16'h0480, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 16'h7C80};

        clr_ctl();
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 16'h0;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_pc", PC, 16'h3000);
        check("rst_cc", CC, 3'b010);
        check("rst_ir", IR, 16'h0);
        check("rst_mdr", MDR, 16'h0);
        check("rst_req", mem_if.mem_req, 1'b0);
        check("rst_ben", BEN, 1'b0);
        check("rst_errs", {mem_err, bus_err, mem_busy}, 3'b000);
        Reset = 1'b1;

        // Reset mid-read
        LD_MDR = 1'b1; MIO_EN = 1'b1;
        tick();
        clr_ctl();
        check("rd_req_up", mem_if.mem_req, 1'b1);
        tick();
        Reset = 1'b0;
        #1;
        check("rst_mid_req", mem_if.mem_req, 1'b0);
        check("rst_mid_busy", mem_busy, 1'b0);
        #2 Reset = 1'b1;
        tick();
        check("rst_rel_pc", PC, 16'h3000);
        check("rst_rel_cc", CC, 3'b010);
        check("rst_rel_busy", mem_busy, 1'b0);

        // MAR <- PC, then read with three cycles of latency
        GatePC = 1'b1; LD_MAR = 1'b1;
        tick();
        clr_ctl();
        check("mar_pc", MAR, 16'h3000);
        mem_read(16'h1234, 3, rc, aseen);
        check("rd_req_cycles", rc, 3);
        check("rd_addr", aseen, 16'h3000);
        check("rd_mdr", MDR, 16'h1234);
        check("rd_busy_done", mem_busy, 1'b0);
        check("rd_req_done", mem_if.mem_req, 1'b0);

        // mem_ready in IDLE is ignored
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'hDEAD;
        tick();
        mem_if.mem_ready = 1'b0;
        check("idle_ready_ign", MDR, 16'h1234);

        // ADD R2,R1,#1 with R1=7FFF
        write_reg(3'd1, 16'h7FFF);
        write_reg(3'd3, 16'h0F0F);
        load_ir(16'h1461);
        SR1MUX = 1'b1; SR2MUX = 1'b1; ALUK = 2'b00; GateALU = 1'b1;
        LD_REG = 1'b1; LD_CC = 1'b1;
        #1;
        check("add_bus", bus, 16'h8000);
        tick();
        clr_ctl();
        check("add_cc", CC, 3'b100);
        load_ir(16'h0880);
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1;
        #1;
        check("r2_val", bus, 16'h8000);
        clr_ctl();
        LD_BEN = 1'b1;
        tick();
        clr_ctl();
        check("ben_n", BEN, 1'b1);
        load_ir(16'h0400);
        LD_CC = 1'b1; LD_BEN = 1'b1;
        tick();
        clr_ctl();
        check("ben_old_cc", BEN, 1'b0);
        check("cc_zero", CC, 3'b010);
        LD_BEN = 1'b1;
        tick();
        clr_ctl();
        check("ben_z", BEN, 1'b1);

        // ALU / address adder table
        foreach (vecs[i]) begin
            load_ir(vecs[i].ir);
            SR1MUX = vecs[i].sr1mux; SR2MUX = vecs[i].sr2mux; ALUK = vecs[i].aluk;
            ADDR1MUX = vecs[i].addr1mux; ADDR2MUX = vecs[i].addr2mux;
            GateALU = ~vecs[i].use_adder; GateMARMUX = vecs[i].use_adder;
            #1;
            check($sformatf("vec%0d_bus", i), bus, vecs[i].exp);
            clr_ctl();
        end

        // PC wrap and hold
        mem_read(16'hFFFF, 1, rc, aseen);
        GateMDR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b01;
        tick();
        clr_ctl();
        check("pc_bus", PC, 16'hFFFF);
        LD_PC = 1'b1; PCMUX = 2'b00;
        tick();
        check("pc_wrap", PC, 16'h0000);
        tick();
        check("pc_inc", PC, 16'h0001);
        PCMUX = 2'b11;
        tick();
        clr_ctl();
        check("pc_hold", PC, 16'h0001);

        // Bus contention
        GatePC = 1'b1; GateALU = 1'b1;
        #1;
        check("conflict_bus", bus, 16'h0);
        check("conflict_pre", bus_err, 1'b0);
        tick();
        clr_ctl();
        check("conflict_set", bus_err, 1'b1);
        tick();
        check("conflict_sticky", bus_err, 1'b1);

        // Write timeout; requests while busy ignored
        MEM_WR = 1'b1;
        tick();
        clr_ctl();
        check("wr_we", mem_if.mem_we, 1'b1);
        check("wr_addr", mem_if.mem_addr, 16'h3000);
        check("wr_wdata", mem_if.mem_wdata, 16'hFFFF);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_busy) break;
            cnt++;
            if (i == 4) begin
                MEM_WR = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b1;
            end
            tick();
            clr_ctl();
        end
        check("tmo_cycles", cnt, 15);
        check("tmo_err", mem_err, 1'b1);
        check("tmo_mdr", MDR, 16'hFFFF);
        tick();
        check("tmo_no_requeue", mem_busy, 1'b0);

        // Read wins over a simultaneous write
        LD_MDR = 1'b1; MIO_EN = 1'b1; MEM_WR = 1'b1;
        tick();
        clr_ctl();
        check("rw_req", mem_if.mem_req, 1'b1);
        check("rw_we", mem_if.mem_we, 1'b0);
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'hA5C3;
        tick();
        mem_if.mem_ready = 1'b0;
        check("rw_mdr", MDR, 16'hA5C3);
        tick();
        check("rw_wr_dropped", mem_busy, 1'b0);

        // Random traffic against the model
        Reset = 1'b0;
        #2 Reset = 1'b1;
        model_reset();
        tick();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [15:0] d;
                d = 16'($urandom);
                mem_read(d, $urandom_range(1, 4), rc, aseen);
                m_mdr = d;
                check("rnd_rd_mdr", MDR, m_mdr);
            end else begin
                rand_step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/slc3_datapath_gen.md
Name: slc3_datapath_gen

Overview:
- Parametrised next-generation SLC-3 datapath: PC/MAR/MDR/IR registers, 8-entry register file, ALU, address adder and a one-hot-gated internal bus, all generalised to DATA_W bits.
- Adds what the first generation lacked: NZP condition codes, BEN, bus-contention detection, and a ready-based memory handshake FSM with timeout.
- Sits between the ISDU control FSM (drives every LD_/Gate/mux input) and the memory/SRAM controller.

Parameters:
- DATA_W, 16, datapath width; >=16; IR fields always occupy bits [15:0].
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, cycles to wait for mem_ready before aborting; 0 disables the timeout.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- LD_MAR, LD_MDR, LD_IR, LD_REG, LD_PC, LD_CC, LD_BEN  in  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers, one-hot
- SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN  in  1 each  mux selects
- PCMUX, ADDR2MUX, ALUK  in  2 each  mux and ALU selects
- MEM_WR  in  1  starts a write of MDR to address MAR
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion strobe
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier
- mem_addr  out  DATA_W  equals MAR
- mem_wdata  out  DATA_W  equals MDR
- mem_busy  out  1  memory FSM not IDLE
- mem_err, bus_err  out  1 each  sticky error flags
- IR, PC, MAR, MDR, bus  out  DATA_W each  architectural values
- CC  out  3  {N,Z,P}
- BEN  out  1  branch enable

Behaviour:
- Reset values: PC=RESET_PC. IR, MAR, MDR and all Rn = 0. CC=3'b010. BEN, mem_req, mem_we, mem_err, bus_err = 0. FSM=IDLE.
- Reset mid-transaction drops mem_req immediately.
- Bus (combinational):
  - No gate asserted: bus = 0.
  - Exactly one gate: bus = PC / MDR / ALU / addr-adder output.
  - Two or more gates: bus = 0, and bus_err is set on the next edge; it stays set until reset.
- SEXT(k) means IR[k-1:0] sign-extended to DATA_W.
- Address adder:
  - ADDR1 = ADDR1MUX ? SR1 : PC.
  - ADDR2MUX: 00 = 0, 01 = SEXT(6), 10 = SEXT(9), 11 = SEXT(11).
  - Sum wraps modulo 2^DATA_W.
- PCMUX (applied when LD_PC=1): 00 = PC+1 (wraps), 01 = bus, 10 = adder output, 11 = PC held.
- Register file:
  - DR = DRMUX ? 7 : IR[11:9].
  - SR1 = SR1MUX ? IR[8:6] : IR[11:9]; SR2 = IR[2:0].
  - Reads are combinational. Write of bus on an edge with LD_REG=1. No same-cycle forwarding.
- ALU:
  - B = SR2MUX ? SEXT(5) : SR2.
  - ALUK: 00 = A+B (wraps), 01 = A&B, 10 = ~A, 11 = A.
- LD_MAR and LD_IR load bus in one cycle.
- CC on LD_CC:
  - N = bus[DATA_W-1].
  - Z = (bus==0).
  - P = neither N nor Z.
- BEN on LD_BEN = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using the pre-edge CC. With both LD_CC and LD_BEN asserted, BEN sees the old CC.
- MDR:
  - LD_MDR with MIO_EN=0 loads bus in one cycle; ignored while mem_busy.
  - LD_MDR with MIO_EN=1 in IDLE starts a read.
- Memory FSM states: IDLE, RD, WR.
- IDLE:
  - LD_MDR&MIO_EN -> RD.
  - Otherwise MEM_WR -> WR.
  - Read wins if both are asserted; the write is dropped.
- RD and WR:
  - Outputs: mem_req=1; mem_we=1 only in WR; mem_addr=MAR; mem_wdata=MDR, all registered and stable for the whole transaction.
  - mem_ready seen on an edge: return to IDLE. In RD, MDR<=mem_rdata on that edge.
  - mem_ready is ignored in IDLE.
  - Minimum latency: request visible the cycle after the start edge; completion on the first edge where mem_ready=1.
- Timeout: the counter resets on entry. After MEM_TIMEOUT cycles without mem_ready, return to IDLE, set mem_err (sticky) and leave MDR unchanged.
- New LD_MDR&MIO_EN or MEM_WR requests are ignored while busy.
- LD_MAR while busy is legal but does not change the in-flight mem_addr, which is latched at start.

Test Plan:
- Reset low mid-RD with RESET_PC=16'h3000 -> mem_req=0 immediately; PC=3000, CC=010, FSM IDLE after release.
- GatePC=1, LD_MAR=1, then MIO_EN=1+LD_MDR=1, mem_ready after 3 cycles with rdata=16'h1234 -> mem_req high 3 cycles, mem_addr=3000, MDR=1234, mem_busy=0.
- R1=16'h7FFF; ADD R2,R1,#1 (SR2MUX=1), GateALU, LD_REG+LD_CC -> R2=8000, CC=100; next cycle LD_BEN with IR[11:9]=100 -> BEN=1.
- PC=16'hFFFF, PCMUX=00, LD_PC -> PC=0000; PCMUX=11 with LD_PC -> PC unchanged.
- GatePC=GateALU=1 -> bus=0, bus_err=1, and it stays set after the gates drop.
- MEM_WR with mem_ready held low, MEM_TIMEOUT=15 -> IDLE after 15 cycles, mem_err=1, MDR unchanged; a MEM_WR issued while busy is ignored.
